// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, the
// default operand width and the bit-counter sizing helper.
package serial_adder_pkg;

   // Default operand/result width in bits
   localparam int DEFAULT_WIDTH = 8;

   // Controller states: waiting, shifting bits through the adder, result pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width able to hold the value WIDTH without wrapping
   function automatic int cnt_bits(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the arithmetic core of the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic c
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in, adds
// one bit per clock through a single full adder, and publishes the sum and
// carry-out together with a one-cycle done pulse.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int                CNT_W    = cnt_bits(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load;
   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .s   (fa_s),
      .c   (fa_c),
      .a   (a_q[0]),
      .b   (b_q[0]),
      .cin (carry_q)
   );

   // State and datapath registers; reset clears everything at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, datapath next values and status outputs
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      busy    = 1'b0;
      done    = 1'b0;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            load = start;
         end
         RUN: begin
            // Sum bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts
            busy    = 1'b1;
            psum_d  = {fa_s, psum_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               sum_d   = {fa_s, psum_q[WIDTH-1:1]};
               cout_d  = fa_c;
               state_d = DONE;
            end
         end
         DONE: begin
            // A new request here chains straight into RUN with no idle gap
            done    = 1'b1;
            state_d = IDLE;
            load    = start;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (load) begin
         a_d     = a;
         b_d     = b;
         carry_d = cin;
         psum_d  = '0;
         cnt_d   = '0;
         state_d = RUN;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed cases plus a
// randomized run compared against plain arithmetic A+B+cin.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int           n_tests;
   int           n_fail;
   logic [W:0]   last_exp;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one addition at the current negedge and follow it to completion.
   // glitch_at: cycle (counted from start) at which a spurious start is pulsed.
   // chain: return on the done cycle so the caller can start back-to-back.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input int glitch_at, input bit chain);
      logic [W:0] exp;
      int         lat;
      int         busy_cnt;
      bit         hold_ok;
      bit         seen;
      bit         both;
      logic       first_busy;
      exp        = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
      a          = av;
      b          = bv;
      cin        = cv;
      start      = 1'b1;
      lat        = 0;
      busy_cnt   = 0;
      hold_ok    = 1'b1;
      seen       = 1'b0;
      both       = 1'b0;
      first_busy = 1'b0;
      while (!seen && lat < W + 6) begin
         @(negedge clk);
         lat++;
         if (lat == 1) first_busy = busy;
         if (busy) busy_cnt++;
         if (busy && done) both = 1'b1;
         if (done) seen = 1'b1;
         else if ({cout, sum} !== last_exp) hold_ok = 1'b0;
         // Scramble inputs after capture; they must not affect the result
         start = 1'b0;
         a     = W'($urandom);
         b     = W'($urandom);
         cin   = 1'($urandom);
         if (glitch_at != 0 && lat == glitch_at) start = 1'b1;
      end
      check("done_seen", 64'(seen), 64'd1);
      check("latency", 64'(lat), 64'(W + 1));
      check("busy_first", 64'(first_busy), 64'd1);
      check("busy_cycles", 64'(busy_cnt), 64'(W));
      check("busy_and_done", 64'(both), 64'd0);
      check("sum_held", 64'(hold_ok), 64'd1);
      check("result", 64'({cout, sum}), 64'(exp));
      $display("[TB] op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d", av, bv, cv, sum, cout, lat);
      last_exp = exp;
      if (!chain) begin
         @(negedge clk);
         check("done_pulse_end", 64'(done), 64'd0);
         check("idle_not_busy", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      last_exp = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      rst_n = 1'b1;

      // Directed operand patterns
      do_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
      do_op(8'h3C, 8'h42, 1'b0, 0, 1'b0);

      // Spurious start three cycles into RUN must be ignored
      do_op(8'h81, 8'h7F, 1'b1, 3, 1'b0);

      // Reset four cycles into RUN
      a     = 8'h77;
      b     = 8'h11;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("midrun_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_busy", 64'(busy), 64'd0);
      check("midrun_rst_done", 64'(done), 64'd0);
      check("midrun_rst_sum", 64'(sum), 64'd0);
      check("midrun_rst_cout", 64'(cout), 64'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("midrun_no_done", 64'(done), 64'd0);
      end
      rst_n    = 1'b1;
      last_exp = '0;
      do_op(8'h12, 8'h34, 1'b1, 0, 1'b0);

      // Back-to-back: second start accepted in DONE, previous sum held
      do_op(8'hC8, 8'h64, 1'b0, 0, 1'b1);
      do_op(8'h10, 8'h20, 1'b0, 0, 1'b0);
      check("b2b_sum", 64'(sum), 64'h30);

      // Randomized operations
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         int           g;
         bit           ch;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
         ch = (i != 999) && ($urandom_range(0, 3) == 0);
         do_op(ra, rb, rc, g, ch);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
